// File: rtl/display_scanner_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package display_scanner_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_W      = 2;

  typedef enum logic {
    StDead = 1'b0,
    StOn   = 1'b1
  } scan_state_e;

  function automatic logic [NUM_DIGITS-1:0] dig_onehot(input logic [DIG_W-1:0] dig);
    return NUM_DIGITS'(1) << dig;
  endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Slot counter and digit index: cnt runs 0..DIV-1 per slot, dig steps once per slot.
module display_scanner_scan_timer
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned CNT_W = $clog2(DIV)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_cnt,
  output logic [DIG_W-1:0] o_dig,
  output logic             o_slot_end,
  output logic             o_frame_end
);

  logic [CNT_W-1:0] r_cnt;
  logic [DIG_W-1:0] r_dig;
  logic             w_slot_end;

  assign w_slot_end = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_dig <= r_dig + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_dig       = r_dig;
  assign o_slot_end  = w_slot_end;
  assign o_frame_end = w_slot_end && (r_dig == DIG_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/display_scanner.sv
// Four-digit seven-segment scanner with per-slot dead time and frame-aligned double buffering.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIV            = 50000,
  parameter int unsigned DEAD           = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] i_seg_in,
  input  logic [NUM_DIGITS-1:0]       i_blank_in,
  input  logic                        i_load,
  output logic                        o_busy,
  output logic [NUM_DIGITS-1:0]       o_an,
  output logic [SEG_W-1:0]            o_seg_out,
  output logic                        o_frame_done
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [NUM_DIGITS-1:0] AnOff  = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [SEG_W-1:0]      SegOff = SEG_ACTIVE_LOW ? '1 : '0;

  if (DIV < 4 || DEAD < 1 || DEAD >= DIV) begin : g_bad_params
    $error("display_scanner: illegal DIV/DEAD combination");
  end

  logic [CntW-1:0]             w_cnt;
  logic [DIG_W-1:0]            w_dig;
  logic                        w_slot_end;
  logic                        w_frame_end;

  scan_state_e                 r_state;
  scan_state_e                 w_state_d;
  logic [NUM_DIGITS*SEG_W-1:0] r_pend_seg;
  logic [NUM_DIGITS-1:0]       r_pend_blank;
  logic                        r_pend_valid;
  logic [NUM_DIGITS*SEG_W-1:0] r_shad_seg;
  logic [NUM_DIGITS-1:0]       r_shad_blank;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [SEG_W-1:0]            r_seg;

  logic                        w_lit;
  logic [SEG_W-1:0]            w_pat;
  logic [NUM_DIGITS-1:0]       w_an_d;
  logic [SEG_W-1:0]            w_seg_d;

  display_scanner_scan_timer #(
    .DIV  (DIV),
    .CNT_W(CntW)
  ) u_scan_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_cnt      (w_cnt),
    .o_dig      (w_dig),
    .o_slot_end (w_slot_end),
    .o_frame_end(w_frame_end)
  );

  always_comb begin
    w_state_d = r_state;
    if (w_slot_end) begin
      w_state_d = StDead;
    end else if (w_cnt == CntW'(DEAD - 1)) begin
      w_state_d = StOn;
    end
  end

  // Dig and shadow only change on edges that also enter DEAD, so current values are safe here.
  assign w_lit   = (w_state_d == StOn) && !r_shad_blank[w_dig];
  assign w_pat   = r_shad_seg[w_dig*SEG_W +: SEG_W];
  assign w_an_d  = w_lit ? (AN_ACTIVE_LOW ? ~dig_onehot(w_dig) : dig_onehot(w_dig)) : AnOff;
  assign w_seg_d = w_lit ? (SEG_ACTIVE_LOW ? ~w_pat : w_pat) : SegOff;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StDead;
      r_pend_seg   <= '0;
      r_pend_blank <= '1;
      r_pend_valid <= 1'b0;
      r_shad_seg   <= '0;
      r_shad_blank <= '1;
      r_an         <= AnOff;
      r_seg        <= SegOff;
    end else begin
      r_state <= w_state_d;
      r_an    <= w_an_d;
      r_seg   <= w_seg_d;
      if (w_frame_end && r_pend_valid) begin
        r_shad_seg   <= r_pend_seg;
        r_shad_blank <= r_pend_blank;
      end
      // A load on the boundary cycle refills pending while the old copy moves to shadow.
      if (i_load) begin
        r_pend_seg   <= i_seg_in;
        r_pend_blank <= i_blank_in;
        r_pend_valid <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign o_busy       = r_pend_valid;
  assign o_an         = r_an;
  assign o_seg_out    = r_seg;
  assign o_frame_done = w_frame_end;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIV=8, DEAD=2 and active-low pins.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] seg_in;
  logic [3:0]  blank_in;
  logic        load;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg_out;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  display_scanner #(
    .DIV           (8),
    .DEAD          (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_seg_in    (seg_in),
    .i_blank_in  (blank_in),
    .i_load      (load),
    .o_busy      (busy),
    .o_an        (an),
    .o_seg_out   (seg_out),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-run pin checks: one anode at most, segments never move while a digit stays lit.
  logic [3:0] prev_an;
  logic [6:0] prev_seg;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
      chk("seg_stable", 32'((seg_out !== prev_seg) && (prev_an != 4'hF) && (an != 4'hF)), 32'd0);
    end
    prev_an  <= an;
    prev_seg <= seg_out;
  end

  // Checks one 32-cycle frame that shows pattern s/blank b; optional loads at offsets la_k, lb_k.
  task automatic run_frame(input string tag, input logic [27:0] s, input logic [3:0] b,
                           input logic [31:0] busy_mask,
                           input int la_k, input logic [27:0] la_s, input logic [3:0] la_b,
                           input int lb_k, input logic [27:0] lb_s, input logic [3:0] lb_b);
    for (int k = 0; k < 32; k++) begin
      int         slot;
      int         cn;
      logic       lit;
      logic [3:0] one;
      logic [3:0] ea;
      logic [6:0] es;
      logic [6:0] pat;
      slot = k / 8;
      cn   = k % 8;
      lit  = (cn >= 2) && !b[slot];
      one  = 4'b0001 << slot;
      pat  = s[slot*7 +: 7];
      ea   = lit ? ~one : 4'hF;
      es   = lit ? ~pat : 7'h7F;
      chk($sformatf("%s_k%0d_an", tag, k), 32'(an), 32'(ea));
      chk($sformatf("%s_k%0d_seg", tag, k), 32'(seg_out), 32'(es));
      chk($sformatf("%s_k%0d_fdone", tag, k), 32'(frame_done), 32'(k == 31));
      chk($sformatf("%s_k%0d_busy", tag, k), 32'(busy), 32'(busy_mask[k]));
      if (k == la_k) begin
        seg_in = la_s; blank_in = la_b; load = 1'b1;
      end else if (k == lb_k) begin
        seg_in = lb_s; blank_in = lb_b; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
  endtask

  localparam logic [27:0] P1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] P2 = {7'h7D, 7'h6D, 7'h3F, 7'h07};
  localparam logic [27:0] PA = {7'h01, 7'h02, 7'h04, 7'h08};
  localparam logic [27:0] PB = {7'h10, 7'h20, 7'h40, 7'h3F};
  localparam logic [27:0] PD = {7'h71, 7'h79, 7'h5E, 7'h39};
  localparam logic [27:0] PC = {7'h76, 7'h38, 7'h73, 7'h1C};
  localparam logic [27:0] P3 = {7'h11, 7'h22, 7'h33, 7'h44};

  initial begin
    rst = 1'b1; seg_in = '0; blank_in = '0; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_an", 32'(an), 32'h0000000F);
    chk("reset_seg", 32'(seg_out), 32'h0000007F);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fdone", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Idle after reset: dark for two frames, frame_done at 31 and 63.
    run_frame("idle0", '0, 4'hF, 32'h0, -1, '0, '0, -1, '0, '0);
    run_frame("idle1", '0, 4'hF, 32'h0, -1, '0, '0, -1, '0, '0);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // Load P1 at cycle 5; it appears in the next frame.
    run_frame("f0", '0, 4'hF, 32'hFFFF_FFC0, 5, P1, 4'h0, -1, '0, '0);
    // Show P1; load P2 with digit 2 blanked.
    run_frame("f1", P1, 4'h0, 32'hFFFF_FE00, 8, P2, 4'b0100, -1, '0, '0);
    // Show P2 with digit 2 dark; two loads, the later one must win.
    run_frame("f2", P2, 4'b0100, 32'hFFFF_FE00, 8, PA, 4'h0, 18, PB, 4'h0);
    // Show PB; load PD, then PC on the boundary cycle itself.
    run_frame("f3", PB, 4'h0, 32'hFFFF_F800, 10, PD, 4'h0, 31, PC, 4'h0);
    // Old pending PD is shown while PC waits a full frame.
    run_frame("f4", PD, 4'h0, 32'hFFFF_FFFF, -1, '0, '0, -1, '0, '0);
    run_frame("f5", PC, 4'h0, 32'h0, -1, '0, '0, -1, '0, '0);

    // Reset during the digit-2 ON phase with a pending load outstanding.
    for (int k = 0; k < 19; k++) begin
      if (k == 5) begin
        seg_in = P3; blank_in = 4'h0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    chk("pre_rst_an", 32'(an), 32'h0000000B);
    chk("pre_rst_seg", 32'(seg_out), 32'h00000047);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_an", 32'(an), 32'h0000000F);
    chk("rst_mid_seg", 32'(seg_out), 32'h0000007F);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_fdone", 32'(frame_done), 32'd0);
    rst = 1'b0;
    run_frame("r0", '0, 4'hF, 32'h0, -1, '0, '0, -1, '0, '0);
    run_frame("r1", '0, 4'hF, 32'h0, -1, '0, '0, -1, '0, '0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
